mem_stage: RTL

- Memory stage of the 5-stage pipeline; sits directly downstream of the EX/MEM pipeline register and consumes its EX_* outputs.
- Performs data-memory loads and stores over a req/ack handshake with variable latency.
- Asserts stall to freeze the upstream stages, including the EX/MEM register's wrt_en, while an access is outstanding.
- Contains the MEM/WB pipeline register that feeds writeback.

---
 rtl/mem_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline.
// Issues data-memory loads and stores over a registered req/ack handshake
// and holds the MEM/WB pipeline register that feeds writeback. While an
// access is outstanding, stall freezes every upstream stage, so the EX_*
// inputs stay stable until the ack arrives.
module mem_stage #(
   parameter int DBITS               = 32,
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int ADDR_BITS           = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [3:0]                     EX_op,
   input  logic [3:0]                     EX_func,
   input  logic [DBITS-1:0]               EX_regData2,
   input  logic [DBITS-1:0]               EX_intermediateResult,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
   input  logic                           EX_ME_mux_sel,
   input  logic                           EX_wrReg,
   input  logic                           EX_wrMem,
   output logic                           dmem_req,
   output logic                           dmem_we,
   output logic [ADDR_BITS-1:0]           dmem_addr,
   output logic [DBITS-1:0]               dmem_wdata,
   input  logic [DBITS-1:0]               dmem_rdata,
   input  logic                           dmem_ack,
   output logic                           stall,
   output logic [3:0]                     MEM_op,
   output logic [3:0]                     MEM_func,
   output logic [DBITS-1:0]               MEM_result,
   output logic [REG_INDEX_BIT_WIDTH-1:0] MEM_rd,
   output logic                           MEM_wrReg
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t               state;
   logic                 mem_op;
   logic                 is_store;
   logic [DBITS-1:0]     access_result;
   logic [ADDR_BITS-1:0] word_addr;

   // Any store or load needs the memory; a store wins when both flags are set.
   assign mem_op   = EX_wrMem | EX_ME_mux_sel;
   assign is_store = EX_wrMem;

   // The byte-offset bits are dropped because only whole words are accessed.
   assign word_addr = EX_intermediateResult[ADDR_BITS+1:2];

   // On completion, a load writes back memory data and a store writes back the ALU value.
   assign access_result = is_store ? EX_intermediateResult : dmem_rdata;

   // Stall while a memory op is being launched or is still waiting for its ack.
   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:    stall = mem_op;
         ACCESS:  stall = ~dmem_ack;
         default: stall = 1'b0;
      endcase
   end

   // Handshake state machine together with the MEM/WB register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         MEM_op     <= '0;
         MEM_func   <= '0;
         MEM_result <= '0;
         MEM_rd     <= '0;
         MEM_wrReg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= is_store;
                  dmem_addr  <= word_addr;
                  dmem_wdata <= EX_regData2;
                  MEM_wrReg  <= 1'b0;
                  state      <= ACCESS;
               end else begin
                  MEM_op     <= EX_op;
                  MEM_func   <= EX_func;
                  MEM_result <= EX_intermediateResult;
                  MEM_rd     <= EX_rd;
                  MEM_wrReg  <= EX_wrReg;
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  dmem_req   <= 1'b0;
                  MEM_op     <= EX_op;
                  MEM_func   <= EX_func;
                  MEM_result <= access_result;
                  MEM_rd     <= EX_rd;
                  MEM_wrReg  <= EX_wrReg;
                  state      <= IDLE;
               end
            end
            default: begin
               dmem_req <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
